// File: rtl/acc_rr_if.sv
// rtl/acc_rr_if.sv - requester/accelerator bundle shared by the round-robin job scheduler
interface acc_rr_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 10
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_op;
  logic [NREQ-1:0]    ack;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic               acc_start;
  logic [DW-1:0]      acc_op;
  logic               acc_done;
  logic [RW-1:0]      acc_result;
  logic               busy;
  logic [2:0]         cur_id;
  logic [7:0]         job_cnt;

  modport master (
    output req, req_op, acc_done, acc_result,
    input  ack, rsp_data, rsp_err, acc_start, acc_op, busy, cur_id, job_cnt
  );

  modport slave (
    input  req, req_op, acc_done, acc_result,
    output ack, rsp_data, rsp_err, acc_start, acc_op, busy, cur_id, job_cnt
  );
endinterface

// File: rtl/acc_rr_scheduler.sv
// rtl/acc_rr_scheduler.sv - round-robin scheduler sharing one accelerator core among NREQ requesters
module acc_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int RW      = 10,
  parameter int TIMEOUT = 1024
) (
  input logic      clk,
  input logic      rst_n,
  acc_rr_if.slave  bus
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic [2:0]      ptr, ptr_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      grant_idx, cur_id_n;
  logic [3:0]      idx;
  logic [DW-1:0]   acc_op_n;
  logic [RW-1:0]   rsp_data_n;
  logic            rsp_err_n;
  logic [7:0]      job_cnt_n;
  logic            acc_start_n;
  logic [NREQ-1:0] ack_n;
  logic [DW-1:0]   op_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_op
    assign op_arr[g] = bus.req_op[g*DW +: DW];
  end

  // Scan from the farthest offset back to ptr so the nearest requester wins last.
  always_comb begin
    grant_idx = '0;
    idx       = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (bus.req[idx[PW-1:0]]) grant_idx = idx[2:0];
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    timer_n     = timer;
    cur_id_n    = bus.cur_id;
    acc_op_n    = bus.acc_op;
    rsp_data_n  = bus.rsp_data;
    rsp_err_n   = bus.rsp_err;
    job_cnt_n   = bus.job_cnt;
    acc_start_n = 1'b0;
    ack_n       = '0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          cur_id_n    = grant_idx;
          acc_op_n    = op_arr[grant_idx[PW-1:0]];
          acc_start_n = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A done arriving on the final timer cycle still counts as success.
        if (bus.acc_done) begin
          rsp_data_n = bus.acc_result;
          rsp_err_n  = 1'b0;
          ack_n[bus.cur_id[PW-1:0]] = 1'b1;
          state_n    = RESP;
        end else if (timer == TW'(TIMEOUT-1)) begin
          rsp_data_n = '0;
          rsp_err_n  = 1'b1;
          ack_n[bus.cur_id[PW-1:0]] = 1'b1;
          state_n    = RESP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      RESP: begin
        ptr_n     = (bus.cur_id == 3'(NREQ-1)) ? 3'd0 : bus.cur_id + 3'd1;
        job_cnt_n = bus.job_cnt + 8'd1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      timer         <= '0;
      bus.ack       <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.acc_start <= 1'b0;
      bus.acc_op    <= '0;
      bus.busy      <= 1'b0;
      bus.cur_id    <= '0;
      bus.job_cnt   <= '0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      timer         <= timer_n;
      bus.ack       <= ack_n;
      bus.rsp_data  <= rsp_data_n;
      bus.rsp_err   <= rsp_err_n;
      bus.acc_start <= acc_start_n;
      bus.acc_op    <= acc_op_n;
      bus.busy      <= (state_n != IDLE);
      bus.cur_id    <= cur_id_n;
      bus.job_cnt   <= job_cnt_n;
    end
  end
endmodule

// File: tb/tb_acc_rr_scheduler.sv
// tb/tb_acc_rr_scheduler.sv - bench for acc_rr_scheduler with a job-level reference model
module tb_acc_rr_scheduler;
  localparam int NREQ    = 4;
  localparam int DW      = 16;
  localparam int RW      = 10;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  acc_rr_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) intf ();

  acc_rr_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Job-level model: a job lives from its grant for a number of cycles
  bit            m_active = 1'b0;
  bit            m_end = 1'b0;
  bit            m_err = 1'b0;
  int            m_ptr = 0;
  int            m_id = 0;
  int            m_age = 0;
  int            m_cnt = 0;
  logic [DW-1:0] m_op = '0;
  logic [RW-1:0] m_data = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_end = 1'b0; m_err = 1'b0;
      m_ptr = 0; m_id = 0; m_age = 0; m_cnt = 0; m_op = '0; m_data = '0;
    end else if (!m_active) begin
      if (intf.req != '0) begin
        for (int k = NREQ-1; k >= 0; k--)
          if (intf.req[(m_ptr + k) % NREQ]) m_id = (m_ptr + k) % NREQ;
        m_op     = intf.req_op[m_id*DW +: DW];
        m_active = 1'b1;
        m_age    = 1;
      end
    end else if (m_end) begin
      m_active = 1'b0;
      m_end    = 1'b0;
      m_cnt    = (m_cnt + 1) % 256;
      m_ptr    = (m_id + 1) % NREQ;
    end else if (m_age >= 2) begin
      if (intf.acc_done) begin
        m_data = intf.acc_result; m_err = 1'b0; m_end = 1'b1;
      end else if (m_age - 2 == TIMEOUT - 1) begin
        m_data = '0; m_err = 1'b1; m_end = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      m_age++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("ack",       32'(intf.ack),       m_end ? (32'd1 << m_id) : 32'd0);
      chk("acc_start", 32'(intf.acc_start), 32'(m_active && m_age == 1));
      chk("busy",      32'(intf.busy),      32'(m_active));
      chk("cur_id",    32'(intf.cur_id),    32'(m_id));
      chk("acc_op",    32'(intf.acc_op),    32'(m_op));
      chk("rsp_data",  32'(intf.rsp_data),  32'(m_data));
      chk("rsp_err",   32'(intf.rsp_err),   32'(m_err));
      chk("job_cnt",   32'(intf.job_cnt),   32'(m_cnt));
    end
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] v);
    intf.req_op[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    intf.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // delay < 0: no done ever; spur: done pulse in ISSUE plus a req_op[1] change after grant
  task automatic job(input int id, input int delay, input logic [RW-1:0] res, input bit spur,
                     input bit drop, input logic exp_err, input logic [RW-1:0] exp_data,
                     input logic [DW-1:0] exp_op, output int s);
    int n;
    n = 0;
    while (intf.acc_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("start_seen", 32'(intf.acc_start), 32'd1);
    chk("grant_id",   32'(intf.cur_id),    32'(id));
    chk("start_op",   32'(intf.acc_op),    32'(exp_op));
    s = cyc;
    if (spur) begin
      intf.acc_done = 1'b1;
      intf.acc_result = 10'h3EE;
      set_op(1, 16'h5555);
      tick();
      intf.acc_done = 1'b0;
    end
    if (delay >= 0) begin
      repeat (delay - (spur ? 1 : 0)) tick();
      intf.acc_done = 1'b1;
      intf.acc_result = res;
      tick();
      intf.acc_done = 1'b0;
    end else begin
      tick();
    end
    n = 0;
    while (intf.ack == '0 && n < TIMEOUT + 20) begin tick(); n++; end
    chk("ack_onehot",  32'(intf.ack),      32'd1 << id);
    chk("ack_data",    32'(intf.rsp_data), 32'(exp_data));
    chk("ack_err",     32'(intf.rsp_err),  32'(exp_err));
    chk("ack_op_held", 32'(intf.acc_op),   32'(exp_op));
    chk("ack_latency", 32'(cyc - s),       (delay >= 0) ? 32'(delay + 1) : 32'(TIMEOUT + 1));
    if (drop) intf.req[id] = 1'b0;
  endtask

  initial begin
    int s, r, n;
    intf.req = '0;
    intf.req_op = '0;
    intf.acc_done = 1'b0;
    intf.acc_result = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy",    32'(intf.busy),    32'd0);
    chk("rst_job_cnt", 32'(intf.job_cnt), 32'd0);
    chk("rst_acc_op",  32'(intf.acc_op),  32'd0);

    // single request
    set_op(0, 16'h1234);
    intf.req = 4'b0001;
    r = cyc;
    job(0, 5, 10'h2AB, 1'b0, 1'b1, 1'b0, 10'h2AB, 16'h1234, s);
    chk("start_latency", 32'(s - r), 32'd1);
    tick();
    chk("job_cnt_single", 32'(intf.job_cnt), 32'd1);

    // round-robin with all requests held
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'hA000 + 16'(i * 'h111));
    intf.req = 4'b1111;
    for (int k = 0; k < 5; k++)
      job(k % NREQ, 3, 10'(37 * k + 5), 1'b0, 1'b0, 1'b0, 10'(37 * k + 5),
          16'hA000 + 16'((k % NREQ) * 'h111), s);
    intf.req = '0;
    tick();
    chk("job_cnt_rr", 32'(intf.job_cnt), 32'd5);

    // timeout, then a normal job
    set_op(2, 16'h0BEE);
    intf.req = 4'b0100;
    job(2, -1, '0, 1'b0, 1'b1, 1'b1, 10'h000, 16'h0BEE, s);
    tick();
    chk("job_cnt_timeout", 32'(intf.job_cnt), 32'd6);
    set_op(0, 16'h0042);
    intf.req = 4'b0001;
    job(0, 2, 10'h099, 1'b0, 1'b1, 1'b0, 10'h099, 16'h0042, s);
    tick();
    chk("job_cnt_after_timeout", 32'(intf.job_cnt), 32'd7);

    // done on the last timer cycle
    set_op(3, 16'h7777);
    intf.req = 4'b1000;
    job(3, TIMEOUT, 10'h155, 1'b0, 1'b1, 1'b0, 10'h155, 16'h7777, s);
    tick();
    chk("job_cnt_coincident", 32'(intf.job_cnt), 32'd8);

    // spurious done in IDLE and ISSUE, operand change after grant
    intf.acc_done = 1'b1;
    intf.acc_result = 10'h3FF;
    tick();
    intf.acc_done = 1'b0;
    tick();
    chk("idle_done_busy", 32'(intf.busy),     32'd0);
    chk("idle_done_data", 32'(intf.rsp_data), 32'h155);
    set_op(1, 16'hAAAA);
    intf.req = 4'b0010;
    job(1, 3, 10'h0C3, 1'b1, 1'b1, 1'b0, 10'h0C3, 16'hAAAA, s);
    tick();
    chk("job_cnt_spur", 32'(intf.job_cnt), 32'd9);

    // asynchronous reset in the middle of WAIT
    set_op(2, 16'h2222);
    intf.req = 4'b0100;
    n = 0;
    while (intf.acc_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rst_job_start", 32'(intf.acc_start), 32'd1);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_ack",       32'(intf.ack),       32'd0);
    chk("async_busy",      32'(intf.busy),      32'd0);
    chk("async_acc_start", 32'(intf.acc_start), 32'd0);
    chk("async_acc_op",    32'(intf.acc_op),    32'd0);
    chk("async_cur_id",    32'(intf.cur_id),    32'd0);
    chk("async_job_cnt",   32'(intf.job_cnt),   32'd0);
    chk("async_rsp_data",  32'(intf.rsp_data),  32'd0);
    chk("async_rsp_err",   32'(intf.rsp_err),   32'd0);
    intf.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    set_op(1, 16'h0101);
    set_op(3, 16'h0303);
    intf.req = 4'b1010;
    job(1, 2, 10'h011, 1'b0, 1'b1, 1'b0, 10'h011, 16'h0101, s);
    job(3, 2, 10'h033, 1'b0, 1'b1, 1'b0, 10'h033, 16'h0303, s);
    tick();
    chk("job_cnt_after_reset", 32'(intf.job_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/acc_rr_scheduler.md
Name: acc_rr_scheduler

Overview:
- Round-robin job scheduler that shares the single accelerator core (10-bit result datapath) among NREQ requesters.
- Arbitrates pending requests and latches the winner's operand.
- Issues a start pulse, waits for done or timeout, then returns the result to the winning requester with a one-cycle ack.
- Sits between the requester logic and the accelerator core inside the accelerator top level.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 16, operand width per requester
RW, 10, accelerator result width
TIMEOUT, 1024, cycles allowed in WAIT before the job is aborted with error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level, held until its ack
req_op  in  NREQ*DW  operands; slice i = req_op[i*DW +: DW]
ack  out  NREQ  one-hot one-cycle completion pulse
rsp_data  out  RW  result, valid only while ack != 0
rsp_err  out  1  timeout flag, valid only while ack != 0
acc_start  out  1  one-cycle start pulse to accelerator
acc_op  out  DW  operand to accelerator, stable from start until job end
acc_done  in  1  one-cycle done pulse from accelerator
acc_result  in  RW  accelerator result, valid with acc_done
busy  out  1  high in any state except IDLE
cur_id  out  3  index of the granted requester; upper bits 0
job_cnt  out  8  completed jobs, including timeouts; wraps 255->0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; rr pointer=0; timer=0.
  - All outputs 0: ack, rsp_data, rsp_err, acc_start, acc_op, busy, cur_id, job_cnt.
  - Reset mid-job abandons the job silently: no ack, no notification to the accelerator.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, grant the first set bit searching ptr, ptr+1, ... mod NREQ.
  - Latch the winner's index into cur_id and its req_op slice into acc_op; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE:
  - acc_start=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT:
  - acc_done=1: capture acc_result into rsp_data, rsp_err=0, go to RESP.
  - Else if timer == TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - Else timer++.
  - acc_done in the same cycle as the timeout limit: done wins, rsp_err=0.
- RESP:
  - ack[cur_id]=1 for exactly this cycle; rsp_data/rsp_err held valid this cycle.
  - ptr <= (cur_id+1) mod NREQ; job_cnt++; go to IDLE.
- Output timing:
  - All outputs registered.
  - acc_op, cur_id, rsp_data, rsp_err hold their values until the next grant or capture.
- Latency:
  - Request seen in IDLE at cycle 0 -> acc_start at cycle 1.
  - acc_done at cycle k -> ack at cycle k+1.
  - Minimum turnaround is 4 cycles; the next grant is possible the cycle after RESP.
- Requester rules:
  - A requester drops req on the edge where it samples ack high.
  - A request withdrawn after grant still completes and is still acked.
  - req_op changes after grant are ignored (operand is latched).
- acc_done outside WAIT is ignored: no state change, no capture.
- Fairness: a requester holding req continuously is served within NREQ jobs.

Test Plan:
- Single request: req=0001, req_op[0]=0x1234; model returns done 5 cycles after start with result 0x2AB -> acc_start at cycle 1 with acc_op=0x1234; ack=0001 one cycle after done; rsp_data=0x2AB, rsp_err=0; job_cnt=1.
- Round-robin: req=1111 held, each job done after 3 cycles -> grant order 0,1,2,3,0; ack reaches each bit once per 4 jobs; the operand matches the granted slice.
- Timeout: req=0100, no acc_done ever -> after TIMEOUT cycles in WAIT, ack=0100 with rsp_err=1, rsp_data=0, job_cnt increments; the next request is served normally.
- Done coincident with timeout: acc_done asserted on the cycle timer==TIMEOUT-1, result 0x155 -> rsp_err=0, rsp_data=0x155.
- Spurious done and operand change: acc_done pulses in IDLE and ISSUE are ignored; changing req_op[1] after grant leaves acc_op unchanged.
- Reset mid-WAIT: rst_n low during WAIT -> all outputs 0 immediately (asynchronously), no ack; after release, a new req=0010 is granted with ptr=0 search order.
